// File: rtl/immediate_materializer_if.sv
// Request/instruction handshake bundle for the immediate materializer.
// master = injector side issuing constants, slave = materializer.
interface immediate_materializer_if #(
  parameter int BIT_COUNT = 32
);
  logic                 ReqValid;
  logic                 ReqReady;
  logic [BIT_COUNT-1:0] Value;
  logic [4:0]           Rd;
  logic                 InstrValid;
  logic                 InstrReady;
  logic [31:0]          InstrOut;
  logic                 Last;
  logic                 Error;

  modport master (
    output ReqValid, Value, Rd, InstrReady,
    input  ReqReady, InstrValid, InstrOut, Last, Error
  );

  modport slave (
    input  ReqValid, Value, Rd, InstrReady,
    output ReqReady, InstrValid, InstrOut, Last, Error
  );
endinterface

// File: rtl/immediate_materializer.sv
// Turns a BIT_COUNT-wide constant into the shortest LUI/ADDI(W) sequence that
// loads it into Rd; one request in flight, valid/ready on both sides.
module immediate_materializer #(
  parameter int BIT_COUNT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  immediate_materializer_if.slave bus
);

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_IMM32 = 7'b0011011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_LOW   = (BIT_COUNT == 64) ? OP_IMM32 : OP_IMM;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t      state_p1, state_n;
  logic [31:0] instr_p1, instr_n;
  logic [31:0] second_p1, second_n;
  logic        last_p1, last_n;
  logic        err_p1, err_n;

  // Upper 20 bits rounded so that adding the sign-extended low 12 bits
  // lands back on the original value.
  function automatic logic [19:0] round_upper(input logic [31:0] v);
    return v[31:12] + {19'd0, v[11]};
  endfunction

  // Value fits a sign-extended 32-bit immediate when all bits from 31 up agree.
  function automatic logic fits_32(input logic [BIT_COUNT-32:0] hi);
    return (&hi) | ~(|hi);
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  // Stage p0: decode of the request as presented on the accept edge
  logic signed [11:0]    low_p0;
  logic [BIT_COUNT-1:0]  low_ext_p0;
  logic [19:0]           upper_p0;
  logic                  small_p0;
  logic                  fits_p0;

  assign low_p0     = bus.Value[11:0];
  assign low_ext_p0 = {{(BIT_COUNT-12){low_p0[11]}}, low_p0};
  assign upper_p0   = round_upper(bus.Value[31:0]);
  assign small_p0   = (bus.Value == low_ext_p0);
  assign fits_p0    = fits_32(bus.Value[BIT_COUNT-1:31]);

  always_comb begin
    state_n  = state_p1;
    instr_n  = instr_p1;
    second_n = second_p1;
    last_n   = last_p1;
    err_n    = 1'b0;
    case (state_p1)
      IDLE: begin
        if (bus.ReqValid) begin
          second_n = enc_i(low_p0, bus.Rd, bus.Rd, OP_LOW);
          if (!fits_p0) begin
            err_n = 1'b1;
          end else begin
            state_n = FIRST;
            if (bus.Rd == 5'd0) begin
              instr_n = NOP;
              last_n  = 1'b1;
            end else if (small_p0) begin
              instr_n = enc_i(low_p0, 5'd0, bus.Rd, OP_IMM);
              last_n  = 1'b1;
            end else begin
              instr_n = {upper_p0, bus.Rd, OP_LUI};
              last_n  = (low_p0 == 12'sd0);
            end
          end
        end
      end
      FIRST: begin
        if (bus.InstrReady) begin
          if (last_p1) begin
            state_n = IDLE;
            last_n  = 1'b0;
          end else begin
            state_n = SECOND;
            instr_n = second_p1;
            last_n  = 1'b1;
          end
        end
      end
      SECOND: begin
        if (bus.InstrReady) begin
          state_n = IDLE;
          last_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p1: registered instruction word and sequence control
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      instr_p1 <= 32'd0;
      last_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_n;
      instr_p1 <= instr_n;
      last_p1  <= last_n;
      err_p1   <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    second_p1 <= second_n;
  end

  assign bus.ReqReady   = (state_p1 == IDLE);
  assign bus.InstrValid = (state_p1 != IDLE);
  assign bus.InstrOut   = instr_p1;
  assign bus.Last       = last_p1;
  assign bus.Error      = err_p1;

endmodule

// File: tb/tb_immediate_materializer.sv
// Scoreboard bench for immediate_materializer: RV32 and RV64 instances share
// one stimulus driver, selected by sel64.
module tb_immediate_materializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  immediate_materializer_if #(.BIT_COUNT(32)) if32();
  immediate_materializer_if #(.BIT_COUNT(64)) if64();

  immediate_materializer #(.BIT_COUNT(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  immediate_materializer #(.BIT_COUNT(64)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

  logic        sel64;
  logic        req_valid;
  logic        instr_ready;
  logic [63:0] value;
  logic [4:0]  rd;

  assign if32.ReqValid   = req_valid & ~sel64;
  assign if64.ReqValid   = req_valid & sel64;
  assign if32.InstrReady = instr_ready & ~sel64;
  assign if64.InstrReady = instr_ready & sel64;
  assign if32.Value      = value[31:0];
  assign if64.Value      = value;
  assign if32.Rd         = rd;
  assign if64.Rd         = rd;

  logic        s_req_ready, s_valid, s_last, s_err;
  logic [31:0] s_out;
  assign s_req_ready = sel64 ? if64.ReqReady   : if32.ReqReady;
  assign s_valid     = sel64 ? if64.InstrValid : if32.InstrValid;
  assign s_out       = sel64 ? if64.InstrOut   : if32.InstrOut;
  assign s_last      = sel64 ? if64.Last       : if32.Last;
  assign s_err       = sel64 ? if64.Error      : if32.Error;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [31:0] i, input logic l);
    exp_t e;
    e.instr = i;
    e.last  = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [63:0] v, input logic [4:0] r, input string name);
    checks++;
    if (s_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s req_ready got=%b want=1", name, s_req_ready);
    end
    value     = v;
    rd        = r;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    value     = ~v;
    rd        = ~r;
  endtask

  // Consume the expected ops, holding InstrReady low for `stall` cycles per op.
  task automatic drain(input int stall, input string name);
    int          budget = 40;
    int          waited = 0;
    bit          held   = 1'b0;
    logic [31:0] held_i;
    logic        held_l;
    exp_t        e;
    while (sb.size() > 0 && budget > 0) begin
      budget--;
      checks++;
      if (s_valid !== 1'b1 || s_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s valid/req_ready got=%b/%b want=1/0", name, s_valid, s_req_ready);
        sb.delete();
        break;
      end
      if (held) begin
        checks++;
        if (s_out !== held_i || s_last !== held_l) begin
          failures++;
          $display("FAIL %s hold got=%h/%b want=%h/%b", name, s_out, s_last, held_i, held_l);
        end
      end
      if (waited < stall) begin
        instr_ready = 1'b0;
        waited++;
        held   = 1'b1;
        held_i = s_out;
        held_l = s_last;
      end else begin
        instr_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (s_out !== e.instr || s_last !== e.last) begin
          failures++;
          $display("FAIL %s op got=%h last=%b want=%h last=%b", name, s_out, s_last, e.instr, e.last);
        end
        waited = 0;
        held   = 1'b0;
      end
      tick();
    end
    instr_ready = 1'b0;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL %s timeout remaining=%0d want=0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (s_valid !== 1'b0 || s_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s done valid/req_ready got=%b/%b want=0/1", name, s_valid, s_req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; instr_ready = 1'b0; sel64 = 1'b0;
    value = '0; rd = '0;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({if32.ReqReady, if32.InstrValid, if32.InstrOut, if32.Last, if32.Error} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset32 got rr=%b v=%b o=%h l=%b e=%b want 1/0/0/0/0",
               if32.ReqReady, if32.InstrValid, if32.InstrOut, if32.Last, if32.Error);
    end
    checks++;
    if ({if64.ReqReady, if64.InstrValid, if64.InstrOut, if64.Last, if64.Error} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset64 got rr=%b v=%b o=%h l=%b e=%b want 1/0/0/0/0",
               if64.ReqReady, if64.InstrValid, if64.InstrOut, if64.Last, if64.Error);
    end
  endtask

  task automatic test_two_op();
    sel64 = 1'b0;
    expect_op(32'h123452B7, 1'b0);
    expect_op(32'h67828293, 1'b1);
    send(64'h12345678, 5'd5, "two_op");
    drain(0, "two_op");
    expect_op(32'h000012B7, 1'b0);
    expect_op(32'hFFF28293, 1'b1);
    send(64'h00000FFF, 5'd5, "round_up");
    drain(0, "round_up");
  endtask

  task automatic test_single();
    sel64 = 1'b0;
    expect_op(32'hFFB00513, 1'b1);
    send(64'hFFFFFFFB, 5'd10, "addi_neg");
    drain(0, "addi_neg");
    expect_op(32'h000420B7, 1'b1);
    send(64'h00042000, 5'd1, "lui_only");
    drain(0, "lui_only");
  endtask

  task automatic test_backpressure();
    sel64 = 1'b0;
    expect_op(32'h123452B7, 1'b0);
    expect_op(32'h67828293, 1'b1);
    send(64'h12345678, 5'd5, "stall");
    drain(3, "stall");
  endtask

  task automatic test_rd_zero();
    sel64 = 1'b0;
    expect_op(32'h00000013, 1'b1);
    send(64'h12345678, 5'd0, "rd0_big");
    drain(0, "rd0_big");
    expect_op(32'h00000013, 1'b1);
    send(64'hFFFFFFFB, 5'd0, "rd0_small");
    drain(1, "rd0_small");
  endtask

  task automatic test_back_to_back();
    sel64 = 1'b0;
    instr_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready valid got=%b want=0", s_valid);
    end
    instr_ready = 1'b0;
    expect_op(32'h7FF00193, 1'b1);
    send(64'h000007FF, 5'd3, "max_pos");
    drain(0, "max_pos");
    expect_op(32'h80000193, 1'b1);
    send(64'hFFFFF800, 5'd3, "min_neg");
    drain(0, "min_neg");
    expect_op(32'h00001137, 1'b0);
    expect_op(32'h80010113, 1'b1);
    send(64'h00000800, 5'd2, "just_over");
    drain(2, "just_over");
  endtask

  task automatic test_rv64();
    sel64 = 1'b1;
    expect_op(32'h800002B7, 1'b0);
    expect_op(32'hFFF2829B, 1'b1);
    send(64'h000000007FFFFFFF, 5'd5, "rv64_addiw");
    drain(0, "rv64_addiw");
    expect_op(32'h800002B7, 1'b1);
    send(64'hFFFFFFFF80000000, 5'd5, "rv64_neg");
    drain(0, "rv64_neg");
  endtask

  task automatic test_error64();
    logic [63:0] bad [2];
    bad[0] = 64'h0000000100000000;
    bad[1] = 64'h0000000080000000;
    sel64 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(bad[i], 5'd5, "err_req");
      checks++;
      if (s_err !== 1'b1 || s_valid !== 1'b0 || s_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL err_pulse[%0d] got e/v/rr=%b/%b/%b want 1/0/1", i, s_err, s_valid, s_req_ready);
      end
      tick();
      checks++;
      if (s_err !== 1'b0 || s_valid !== 1'b0 || s_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL err_clear[%0d] got e/v/rr=%b/%b/%b want 0/0/1", i, s_err, s_valid, s_req_ready);
      end
    end
    sel64 = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel64 = 1'b0;
    send(64'h12345678, 5'd5, "rst_mid");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (s_out !== 32'h67828293 || s_last !== 1'b1 || s_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid second got=%h/%b/%b want 67828293/1/1", s_out, s_last, s_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({s_valid, s_req_ready, s_out, s_last} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid state got v=%b rr=%b o=%h l=%b want 0/1/0/0", s_valid, s_req_ready, s_out, s_last);
    end
    repeat (2) tick();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid quiet valid got=%b want=0", s_valid);
    end
    expect_op(32'h123452B7, 1'b0);
    expect_op(32'h67828293, 1'b1);
    send(64'h12345678, 5'd5, "after_rst");
    drain(0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_two_op();
    test_single();
    test_backpressure();
    test_rd_zero();
    test_back_to_back();
    test_rv64();
    test_error64();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
